// File: rtl/pipeline_scoreboard.sv
// Per-register countdown scoreboard producing stall/flush controls for a five-stage pipeline.
// Covers ALU ops, loads and multi-cycle units with latency up to 2^LATW-1.
module pipeline_scoreboard #(
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned LATW = 3,
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_d,
    input  logic [AW-1:0]   RS1_D,
    input  logic [AW-1:0]   RS2_D,
    input  logic            use_rs1_d,
    input  logic            use_rs2_d,
    input  logic [AW-1:0]   RD_D,
    input  logic            RegWrite_D,
    input  logic [LATW-1:0] Lat_D,
    input  logic            PCSrcE,
    output logic            StallF,
    output logic            StallD,
    output logic            FlushD,
    output logic            FlushE,
    output logic [NREG-1:0] busy,
    output logic [CNTW-1:0] stall_count
);

    localparam logic [AW:0] NregW = (AW+1)'(NREG);

    logic [LATW-1:0] cnt_q [NREG];
    logic [LATW-1:0] cnt_d [NREG];
    logic [CNTW-1:0] stall_count_q;
    logic [CNTW-1:0] stall_count_d;

    logic            rs1_ok, rs2_ok, rd_ok;
    logic [LATW-1:0] rs1_cnt, rs2_cnt, rd_cnt;
    logic [LATW-1:0] lat_n;
    logic            raw, waw, hazard, issue, alloc;

    // Index 0 and indices beyond NREG are never tracked.
    assign rs1_ok = (RS1_D != '0) && ({1'b0, RS1_D} < NregW);
    assign rs2_ok = (RS2_D != '0) && ({1'b0, RS2_D} < NregW);
    assign rd_ok  = (RD_D  != '0) && ({1'b0, RD_D}  < NregW);

    assign rs1_cnt = rs1_ok ? cnt_q[RS1_D] : '0;
    assign rs2_cnt = rs2_ok ? cnt_q[RS2_D] : '0;
    assign rd_cnt  = rd_ok  ? cnt_q[RD_D]  : '0;

    assign lat_n = (Lat_D == '0) ? '0 : Lat_D - LATW'(1);

    assign raw    = (use_rs1_d && (rs1_cnt != '0)) || (use_rs2_d && (rs2_cnt != '0));
    assign waw    = RegWrite_D && rd_ok && (rd_cnt > lat_n);
    assign hazard = valid_d && (raw || waw);
    assign issue  = valid_d && !hazard && !PCSrcE;
    assign alloc  = issue && RegWrite_D && rd_ok;

    always_comb begin
        cnt_d[0] = '0;
        for (int unsigned r = 1; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            // A fresh allocation overrides the countdown in the same cycle.
            if (alloc && (RD_D == AW'(r))) begin
                cnt_d[r] = lat_n;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - LATW'(1);
            end
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (hazard && !PCSrcE && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            stall_count_q <= '0;
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            stall_count_q <= stall_count_d;
        end
    end

    always_comb begin
        for (int unsigned r = 0; r < NREG; r++) begin
            busy[r] = (cnt_q[r] != '0);
        end
    end

    assign stall_count = stall_count_q;

    // Branch redirect outranks a hazard; a held reset flushes both boundaries.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        if (!rst || PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (hazard) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Scoreboard-driven bench for pipeline_scoreboard: expected control words are queued as stimulus
// is applied and popped when the outputs are sampled on the falling edge.
module tb_pipeline_scoreboard;

    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned LATW = 3;
    localparam int unsigned CNTW = 4;

    // {StallF, StallD, FlushD, FlushE}
    localparam logic [3:0] CtlNone  = 4'b0000;
    localparam logic [3:0] CtlStall = 4'b1101;
    localparam logic [3:0] CtlFlush = 4'b0011;

    logic            clk, rst;
    logic            valid_d, use_rs1_d, use_rs2_d, RegWrite_D, PCSrcE;
    logic [AW-1:0]   RS1_D, RS2_D, RD_D;
    logic [LATW-1:0] Lat_D;
    logic            StallF, StallD, FlushD, FlushE;
    logic [NREG-1:0] busy;
    logic [CNTW-1:0] stall_count;
    logic [3:0]      ctl;

    int vectors     = 0;
    int miscompares = 0;
    logic [3:0] exp_q [$];
    logic [3:0] e;

    assign ctl = {StallF, StallD, FlushD, FlushE};

    pipeline_scoreboard #(
        .NREG(NREG), .AW(AW), .LATW(LATW), .CNTW(CNTW)
    ) dut (
        .clk(clk), .rst(rst), .valid_d(valid_d), .RS1_D(RS1_D), .RS2_D(RS2_D),
        .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d), .RD_D(RD_D), .RegWrite_D(RegWrite_D),
        .Lat_D(Lat_D), .PCSrcE(PCSrcE), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .FlushE(FlushE), .busy(busy), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic [2:0] lat, input logic br);
        valid_d = v; RS1_D = rs1; use_rs1_d = u1; RS2_D = rs2; use_rs2_d = u2;
        RD_D = rd; RegWrite_D = rw; Lat_D = lat; PCSrcE = br;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        next_cycle();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), 5'($urandom), 1'($urandom), 5'($urandom), 1'($urandom),
                  5'($urandom), 1'($urandom), 3'($urandom), 1'($urandom));
            exp_q.push_back(CtlFlush);
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (ctl !== e) begin
                miscompares++;
                $display("FAIL reset_ctl cyc %0d: got %b want %b", i, ctl, e);
            end
            vectors++;
            if (busy !== '0 || stall_count !== '0) begin
                miscompares++;
                $display("FAIL reset_state cyc %0d: busy %h cnt %0d want 0/0", i, busy, stall_count);
            end
            next_cycle();
        end
        rst = 1'b1;
        idle();
        exp_q.push_back(CtlNone);
        @(negedge clk);
        e = exp_q.pop_front();
        vectors++;
        if (ctl !== e) begin
            miscompares++;
            $display("FAIL reset_release ctl: got %b want %b", ctl, e);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        // Lat 1 then Lat 0 (treated as 1): dependents never stall.
        for (int k = 0; k < 2; k++) begin
            drive(1, 0, 0, 0, 0, 5'(4 + k), 1, 3'(k == 0 ? 1 : 0), 0);
            exp_q.push_back(CtlNone);
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (ctl !== e) begin
                miscompares++;
                $display("FAIL b2b_issue lat%0d: got %b want %b", 1 - k, ctl, e);
            end
            next_cycle();
            drive(1, 5'(4 + k), 1, 0, 0, 0, 0, 1, 0);
            exp_q.push_back(CtlNone);
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (ctl !== e || busy[4 + k] !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_dep lat%0d: ctl %b busy %b want %b 0", 1 - k, ctl, busy[4 + k], e);
            end
            next_cycle();
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 0, 0, 0, 0, 5, 1, 2, 0);
        exp_q.push_back(CtlNone);
        @(negedge clk);
        e = exp_q.pop_front();
        vectors++;
        if (ctl !== e) begin
            miscompares++;
            $display("FAIL load_use_issue: got %b want %b", ctl, e);
        end
        next_cycle();
        drive(1, 5, 1, 0, 0, 0, 0, 1, 0);
        exp_q.push_back(CtlStall);
        exp_q.push_back(CtlNone);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (ctl !== e) begin
                miscompares++;
                $display("FAIL load_use_dep cyc %0d: got %b want %b", i, ctl, e);
            end
            next_cycle();
        end
        idle();
        @(negedge clk);
        vectors++;
        if (stall_count !== 4'd1) begin
            miscompares++;
            $display("FAIL load_use_count: got %0d want 1", stall_count);
        end
        next_cycle();
    endtask

    task automatic test_multicycle();
        do_reset();
        drive(1, 0, 0, 0, 0, 7, 1, 5, 0);
        exp_q.push_back(CtlNone);
        @(negedge clk);
        e = exp_q.pop_front();
        vectors++;
        if (ctl !== e || busy[7] !== 1'b0) begin
            miscompares++;
            $display("FAIL multi_issue: ctl %b busy7 %b want %b 0", ctl, busy[7], e);
        end
        next_cycle();
        drive(1, 0, 0, 7, 1, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) exp_q.push_back(CtlStall);
        exp_q.push_back(CtlNone);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (ctl !== e || busy[7] !== (i < 4)) begin
                miscompares++;
                $display("FAIL multi_dep cyc %0d: ctl %b busy7 %b want %b %b",
                         i, ctl, busy[7], e, (i < 4));
            end
            next_cycle();
        end
        idle();
        @(negedge clk);
        vectors++;
        if (stall_count !== 4'd4) begin
            miscompares++;
            $display("FAIL multi_count: got %0d want 4", stall_count);
        end
        next_cycle();
    endtask

    task automatic test_branch_override();
        do_reset();
        drive(1, 0, 0, 0, 0, 3, 1, 3, 0);
        exp_q.push_back(CtlNone);
        @(negedge clk);
        e = exp_q.pop_front();
        next_cycle();
        // x3 pending with count 2, redirect in execute.
        drive(1, 3, 1, 0, 0, 11, 1, 1, 1);
        exp_q.push_back(CtlFlush);
        @(negedge clk);
        e = exp_q.pop_front();
        vectors++;
        if (ctl !== e) begin
            miscompares++;
            $display("FAIL branch_ctl: got %b want %b", ctl, e);
        end
        next_cycle();
        idle();
        @(negedge clk);
        vectors++;
        if (busy[11] !== 1'b0 || busy[3] !== 1'b1 || stall_count !== 4'd0) begin
            miscompares++;
            $display("FAIL branch_state: busy11 %b busy3 %b cnt %0d want 0 1 0",
                     busy[11], busy[3], stall_count);
        end
        next_cycle();
    endtask

    task automatic test_x0_waw();
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 1, 7, 0);
        next_cycle();
        idle();
        @(negedge clk);
        vectors++;
        if (busy !== '0) begin
            miscompares++;
            $display("FAIL x0_busy: got %h want 0", busy);
        end
        next_cycle();
        drive(1, 0, 0, 0, 0, 9, 1, 4, 0);
        next_cycle();
        idle();
        next_cycle();
        // Count is now 2; a Lat 1 rewrite of x9 must wait while count > 0.
        drive(1, 0, 0, 0, 0, 9, 1, 1, 0);
        exp_q.push_back(CtlStall);
        exp_q.push_back(CtlStall);
        exp_q.push_back(CtlNone);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (ctl !== e) begin
                miscompares++;
                $display("FAIL waw cyc %0d: got %b want %b", i, ctl, e);
            end
            next_cycle();
        end
        idle();
        @(negedge clk);
        vectors++;
        if (stall_count !== 4'd2 || busy[9] !== 1'b0) begin
            miscompares++;
            $display("FAIL waw_state: cnt %0d busy9 %b want 2 0", stall_count, busy[9]);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive(1, 0, 0, 0, 0, 8, 1, 7, 0);
        next_cycle();
        drive(1, 8, 1, 0, 0, 0, 0, 1, 0);
        exp_q.push_back(CtlStall);
        @(negedge clk);
        e = exp_q.pop_front();
        vectors++;
        if (ctl !== e) begin
            miscompares++;
            $display("FAIL midrst_stall: got %b want %b", ctl, e);
        end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (busy !== '0 || ctl !== CtlFlush) begin
            miscompares++;
            $display("FAIL midrst_async: busy %h ctl %b want 0 %b", busy, ctl, CtlFlush);
        end
        next_cycle();
        rst = 1'b1;
        exp_q.push_back(CtlNone);
        @(negedge clk);
        e = exp_q.pop_front();
        vectors++;
        if (ctl !== e || stall_count !== 4'd0) begin
            miscompares++;
            $display("FAIL midrst_release: ctl %b cnt %0d want %b 0", ctl, stall_count, e);
        end
        next_cycle();
    endtask

    task automatic test_saturation();
        int sat;
        do_reset();
        sat = 0;
        // Self-dependent Lat 7 op: issues once, then stalls six cycles, repeating.
        drive(1, 10, 1, 0, 0, 10, 1, 7, 0);
        for (int i = 0; i < 30; i++) begin
            exp_q.push_back((i % 7 == 0) ? CtlNone : CtlStall);
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (ctl !== e || stall_count !== 4'(sat)) begin
                miscompares++;
                $display("FAIL sat cyc %0d: ctl %b cnt %0d want %b %0d",
                         i, ctl, stall_count, e, sat);
            end
            if (e == CtlStall && sat < 15) sat++;
            next_cycle();
        end
        idle();
        @(negedge clk);
        vectors++;
        if (stall_count !== 4'd15) begin
            miscompares++;
            $display("FAIL sat_final: got %0d want 15", stall_count);
        end
        next_cycle();
    endtask

    initial begin
        rst = 1'b0;
        idle();
        test_reset();
        test_back_to_back();
        test_load_use();
        test_multicycle();
        test_branch_override();
        test_x0_waw();
        test_reset_mid_stall();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_scoreboard.md
# pipeline_scoreboard

Parametrised hazard controller for the five-stage RISC-V pipeline. It replaces fixed load-use detection with a per-register countdown scoreboard, so the same block covers single-cycle ALU ops, loads, and multi-cycle units of any latency up to a parameter limit. It sits beside the decode/execute boundary and produces StallF, StallD, FlushD and FlushE. It also exposes a busy vector and a stall-cycle counter for debug.

## Interface
- NREG, 32, architectural register count; register 0 is never tracked
- AW, 5, register index width; must satisfy 2^AW >= NREG
- LATW, 3, latency field width; maximum latency is 2^LATW-1
- CNTW, 16, width of the stall-cycle statistics counter
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- valid_d  in  1  decode stage holds a real instruction
- RS1_D, RS2_D  in  AW each  source indices in decode
- use_rs1_d, use_rs2_d  in  1 each  instruction actually reads that source
- RD_D  in  AW  destination index in decode
- RegWrite_D  in  1  instruction writes RD_D
- Lat_D  in  LATW  cycles from issue until the result can be forwarded; 0 is treated as 1
- PCSrcE  in  1  taken branch/jump resolved in execute
- StallF, StallD  out  1  hold PC and the IF/ID register
- FlushD, FlushE  out  1  clear the IF/ID and ID/EX registers
- busy  out  NREG  bit r set while cnt[r] != 0
- stall_count  out  CNTW  saturating count of hazard-stall cycles

## Operation
- State: cnt[r], LATW bits, for r = 1..NREG-1. cnt[0] is hard-wired to 0.
- Normalised latency: L' = max(Lat_D, 1) - 1.
- RAW hazard: (use_rs1_d & cnt[RS1_D] != 0) | (use_rs2_d & cnt[RS2_D] != 0).
- WAW hazard: RegWrite_D & RD_D != 0 & cnt[RD_D] > L'.
- hazard = valid_d & (RAW | WAW).
- issue = valid_d & ~hazard & ~PCSrcE.
- Output priority, evaluated combinationally:
  - PCSrcE=1: FlushD=1, FlushE=1, StallF=0, StallD=0. The decode instruction is discarded and no entry is made.
  - Else if hazard: StallF=1, StallD=1, FlushE=1 to insert a bubble, FlushD=0.
  - Else all four outputs are 0.
- Counter update every clock edge, for each r:
  - If issue & RegWrite_D & RD_D == r & r != 0: cnt[r] <= L'. A new issue wins over the decrement in the same cycle.
  - Else if cnt[r] != 0: cnt[r] <= cnt[r] - 1.
  - Else cnt[r] holds.
- stall_count increments on each cycle where hazard & ~PCSrcE. It saturates at 2^CNTW-1 and never wraps.
- Indices >= NREG are treated as register 0: never busy, never allocated.

## Timing
- Reset (rst=0, asynchronous):
  - All cnt cleared, busy=0, stall_count=0.
  - While rst=0, FlushD=1, FlushE=1, StallF=0, StallD=0.
- Stall and flush outputs are combinational from the current inputs and registered state: zero-cycle latency.
- busy reflects the registered counters only, so it updates one cycle after issue.
- Issuing in cycle t with Lat_D=L lets a dependent instruction in decode issue no earlier than cycle t+L:
  - L=1: back-to-back, no stall.
  - L=2: one bubble (load-use).
  - L=5: four bubbles.
- A reset asserted mid-stall drops all pending entries. After release, decode proceeds with no stall.
- If PCSrcE and hazard are both 1 in the same cycle, PCSrcE wins, and that cycle does not increment stall_count.

## Test plan
- Reset: drive rst=0 for 3 cycles with random inputs -> busy=0, stall_count=0, FlushD=FlushE=1, StallF=StallD=0. After release, all four are 0 while valid_d=0.
- Load-use: issue RD_D=5, Lat_D=2, then decode reads RS1_D=5 -> exactly 1 cycle of StallF=StallD=FlushE=1. Issue in the next cycle. stall_count=1.
- Multi-cycle op: issue RD_D=7, Lat_D=5, then a dependent on RS2_D=7 -> 4 stall cycles. busy[7] is high for 4 cycles starting one cycle after issue.
- Branch override: pending cnt[3]=2, decode reads x3, PCSrcE=1 -> FlushD=FlushE=1, StallF=0, no allocation, stall_count unchanged.
- x0 and WAW:
  - Issue RD_D=0, Lat_D=7 -> busy stays 0.
  - Issue RD_D=9, Lat_D=4, then RD_D=9, Lat_D=1 with no source use -> WAW stalls 2 cycles, then issues.
- Saturation: with CNTW=4, hold a permanent RAW hazard for 20 cycles -> stall_count stops at 15.
